multicycle_controller: RTL

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller_pkg.sv | 57 +++++
 rtl/multicycle_controller_cond_check.sv | 38 +++
 rtl/multicycle_controller.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_pkg.sv
// multicycle_controller_pkg: shared states, field encodings and helpers for the multicycle controller
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXECR,
        EXECI,
        ALUWB,
        BRANCH,
        FAULT
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [1:0] IMM_8  = 2'b00;
    localparam logic [1:0] IMM_12 = 2'b01;
    localparam logic [1:0] IMM_24 = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [3:0] CMD_CMP = 4'b1010;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    function automatic logic is_wait_state(input state_t s);
        return s == FETCH || s == MEMRD || s == MEMWR;
    endfunction

endpackage

// File: rtl/multicycle_controller_cond_check.sv
// cond_check: evaluates an ARM condition field against the registered NZCV flags
module cond_check
    import multicycle_controller_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       condEx
);

    logic n, z, c, v;

    assign {n, z, c, v} = flags;

    // one entry per condition code; the reserved code never executes
    always_comb begin
        condEx = 1'b0;
        case (cond)
            COND_EQ: condEx = z;
            COND_NE: condEx = !z;
            COND_CS: condEx = c;
            COND_CC: condEx = !c;
            COND_MI: condEx = n;
            COND_PL: condEx = !n;
            COND_VS: condEx = v;
            COND_VC: condEx = !v;
            COND_HI: condEx = c && !z;
            COND_LS: condEx = !c || z;
            COND_GE: condEx = n == v;
            COND_LT: condEx = n != v;
            COND_GT: condEx = !z && (n == v);
            COND_LE: condEx = z || (n != v);
            COND_AL: condEx = 1'b1;
            COND_NV: condEx = 1'b0;
            default: condEx = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore control FSM for a multicycle ARM-style datapath with memory-wait timeout
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic [3:0]  aluFlags,
    input  logic        memReady,
    output logic        memRead,
    output logic        memW,
    output logic        irWrite,
    output logic        pcWrite,
    output logic        regW,
    output logic        adrSrc,
    output logic        aluSrcA,
    output logic [1:0]  aluSrcB,
    output logic [1:0]  resultSrc,
    output logic [1:0]  immSrc,
    output logic        aluOp,
    output logic        fault,
    output logic [3:0]  flags
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_t        state, state_next;
    logic [CW-1:0] wait_cnt;
    logic [3:0]    cond, rd;
    logic [1:0]    op;
    logic [5:0]    funct;
    logic          cond_ex, is_cmp, timeout;
    logic          ir_w, pc_w, reg_w, mem_w;
    logic          unused_bits;

    assign cond        = instr[31:28];
    assign op          = instr[27:26];
    assign funct       = instr[25:20];
    assign rd          = instr[15:12];
    assign unused_bits = ^{instr[19:16], instr[11:0]};
    assign is_cmp      = funct[4:1] == CMD_CMP;
    assign timeout     = wait_cnt == CW'(TIMEOUT_CYCLES - 1);

    cond_check u_cond_check (
        .cond   (cond),
        .flags  (flags),
        .condEx (cond_ex)
    );

    // write strobes are held off for as long as reset is asserted
    assign irWrite = ir_w & rst_n;
    assign pcWrite = pc_w & rst_n;
    assign regW    = reg_w & rst_n;
    assign memW    = mem_w & rst_n;

    // state register and memory-wait counter, cleared whenever a wait state is entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= (state_next == state && is_wait_state(state)) ? wait_cnt + CW'(1) : '0;
        end
    end

    // NZCV only updates on the write-back of an S-suffixed data-processing instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) flags <= 4'b0000;
        else if (state == ALUWB && funct[0]) flags <= aluFlags;
    end

    // next-state decode and Moore outputs (FETCH strobes also follow memReady)
    always_comb begin
        state_next = state;
        memRead    = 1'b0;
        mem_w      = 1'b0;
        ir_w       = 1'b0;
        pc_w       = 1'b0;
        reg_w      = 1'b0;
        adrSrc     = 1'b0;
        aluSrcA    = 1'b0;
        aluSrcB    = SRCB_REG;
        resultSrc  = RES_ALUOUT;
        immSrc     = IMM_8;
        aluOp      = 1'b0;
        fault      = 1'b0;
        case (state)
            FETCH: begin
                memRead    = 1'b1;
                aluSrcA    = 1'b1;
                aluSrcB    = SRCB_FOUR;
                resultSrc  = RES_ALURES;
                ir_w       = memReady;
                pc_w       = memReady;
                state_next = memReady ? DECODE : timeout ? FAULT : FETCH;
            end
            DECODE: begin
                aluSrcA    = 1'b1;
                aluSrcB    = SRCB_FOUR;
                resultSrc  = RES_ALURES;
                state_next = !cond_ex       ? FETCH :
                             op == OP_DP    ? (funct[5] ? EXECI : EXECR) :
                             op == OP_MEM   ? MEMADR :
                             op == OP_BR    ? BRANCH : FAULT;
            end
            MEMADR: begin
                aluSrcB    = SRCB_IMM;
                immSrc     = IMM_12;
                state_next = funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                memRead    = 1'b1;
                adrSrc     = 1'b1;
                state_next = memReady ? MEMWB : timeout ? FAULT : MEMRD;
            end
            MEMWB: begin
                reg_w      = 1'b1;
                resultSrc  = RES_DATA;
                state_next = FETCH;
            end
            MEMWR: begin
                mem_w      = 1'b1;
                adrSrc     = 1'b1;
                state_next = memReady ? FETCH : timeout ? FAULT : MEMWR;
            end
            EXECR: begin
                aluOp      = 1'b1;
                state_next = ALUWB;
            end
            EXECI: begin
                aluOp      = 1'b1;
                aluSrcB    = SRCB_IMM;
                state_next = ALUWB;
            end
            ALUWB: begin
                reg_w      = !is_cmp;
                pc_w       = !is_cmp && rd == 4'hF;
                state_next = FETCH;
            end
            BRANCH: begin
                immSrc     = IMM_24;
                aluSrcB    = SRCB_IMM;
                resultSrc  = RES_ALURES;
                pc_w       = 1'b1;
                state_next = FETCH;
            end
            FAULT: fault = 1'b1;
            default: state_next = FAULT;
        endcase
    end

endmodule
